// File: rtl/rs_pkg.sv
// Shared types and helpers for the reservation-station queue family.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rs_pkg;

  localparam int RS_XLEN    = 32;
  localparam int RS_PREG_W  = 6;
  localparam int RS_MAX_CDB = 4;
  localparam int RS_DEPTH   = 8;
  localparam int CNT_W      = $clog2(RS_DEPTH + 1);
  localparam int RS_TAGS_W  = RS_MAX_CDB * RS_PREG_W;

  // One queued instruction with per-source readiness.
  typedef struct packed {
    logic [RS_XLEN-1:0]   pc;
    logic [RS_XLEN-1:0]   inst;
    logic [RS_PREG_W-1:0] prs1;
    logic                 rdy1;
    logic [RS_PREG_W-1:0] prs2;
    logic                 rdy2;
    logic [RS_PREG_W-1:0] prd;
  } rs_entry_t;

  // True when any enabled broadcast channel carries the given tag.
  // Channels are zero-extended to RS_MAX_CDB by the caller; unused ones stay disabled.
  function automatic logic tag_match(input logic [RS_PREG_W-1:0]  tag,
                                     input logic [RS_MAX_CDB-1:0] cdb_en,
                                     input logic [RS_TAGS_W-1:0]  cdb_tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < RS_MAX_CDB; k++) begin
      if (cdb_en[k] && (cdb_tag[k*RS_PREG_W +: RS_PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/rs_select.sv
// Priority encoder: reports whether any request is set and the lowest set index.
// Latency: purely combinational.
// Backpressure: none.
// Ports: req_i (N request bits), found_o (any set), idx_o (lowest set index, 0 if none).
module rs_select #(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    found_o = |req_i;
    idx_o   = '0;
    // Scan from the top so the lowest (oldest) index wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rs_queue.sv
// Age-ordered collapsing reservation station with CDB wakeup and oldest-ready issue.
// Latency: wakeup-to-issue 1 cycle; alloc-to-issue 1 cycle when sources are ready.
// Backpressure: alloc_ready_o drops when full (registered); offered entry holds while fu_ready_i is low.
// Ports: clk_i/reset_ni, flush_i; alloc_* + pc/inst/prs*/prd inputs; cdb_en_i/cdb_tag_i wakeup;
//        issue_valid_o/fu_ready_i handshake with issue_* entry fields; count_o occupancy.
module rs_queue
  import rs_pkg::*;
#(
  parameter int DEPTH           = 8,
  parameter int NUM_CDB         = 2,
  parameter int PREG_W          = RS_PREG_W,
  parameter int XLEN            = RS_XLEN,
  parameter bit P0_ALWAYS_READY = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic                        flush_i,
  input  logic                        alloc_valid_i,
  output logic                        alloc_ready_o,
  input  logic [XLEN-1:0]             pc_i,
  input  logic [XLEN-1:0]             inst_i,
  input  logic [PREG_W-1:0]           prs1_addr_i,
  input  logic [PREG_W-1:0]           prs2_addr_i,
  input  logic [PREG_W-1:0]           prd_addr_i,
  input  logic                        prs1_valid_i,
  input  logic                        prs2_valid_i,
  input  logic [NUM_CDB-1:0]          cdb_en_i,
  input  logic [NUM_CDB*PREG_W-1:0]   cdb_tag_i,
  output logic                        issue_valid_o,
  input  logic                        fu_ready_i,
  output logic [XLEN-1:0]             issue_pc_o,
  output logic [XLEN-1:0]             issue_inst_o,
  output logic [PREG_W-1:0]           issue_prs1_addr_o,
  output logic [PREG_W-1:0]           issue_prs2_addr_o,
  output logic [PREG_W-1:0]           issue_prd_addr_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o
);

  // The entry layout is fixed by rs_pkg; PREG_W/XLEN overrides must match it.
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t        entries_q [DEPTH];
  rs_entry_t        entries_d [DEPTH];
  rs_entry_t        woken     [DEPTH];
  rs_entry_t        shifted   [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  logic [RS_MAX_CDB-1:0] cdb_en_ext;
  logic [RS_TAGS_W-1:0]  cdb_tag_ext;
  logic [DEPTH-1:0]      ready_vec;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  rs_entry_t             sel_e;
  rs_entry_t             new_e;
  logic                  alloc_fire, issue_fire;
  logic [CW-1:0]         wr_slot;

  assign cdb_en_ext  = RS_MAX_CDB'(cdb_en_i);
  assign cdb_tag_ext = RS_TAGS_W'(cdb_tag_i);

  // Eligibility uses registered ready bits only: no CDB-to-issue combinational path.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = (CW'(i) < count_q) && entries_q[i].rdy1 && entries_q[i].rdy2;
    end
  end

  rs_select #(.N(DEPTH), .IDX_W(IDX_W)) u_select (
    .req_i   (ready_vec),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  always_comb begin
    sel_e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_found && (IDX_W'(i) == sel_idx)) sel_e = entries_q[i];
    end
  end

  assign issue_valid_o     = sel_found;
  assign issue_pc_o        = sel_e.pc;
  assign issue_inst_o      = sel_e.inst;
  assign issue_prs1_addr_o = sel_e.prs1;
  assign issue_prs2_addr_o = sel_e.prs2;
  assign issue_prd_addr_o  = sel_e.prd;

  // Full station refuses allocation even if an issue frees a slot this cycle.
  assign alloc_ready_o = (count_q < CW'(DEPTH));
  assign count_o       = count_q;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o && !flush_i;
  assign issue_fire    = sel_found && fu_ready_i && !flush_i;
  assign wr_slot       = count_q - CW'(issue_fire);

  // Incoming entry also captures broadcasts seen in its allocation cycle.
  always_comb begin
    new_e      = '0;
    new_e.pc   = pc_i;
    new_e.inst = inst_i;
    new_e.prs1 = prs1_addr_i;
    new_e.prs2 = prs2_addr_i;
    new_e.prd  = prd_addr_i;
    new_e.rdy1 = prs1_valid_i || (P0_ALWAYS_READY && (prs1_addr_i == '0))
                 || tag_match(prs1_addr_i, cdb_en_ext, cdb_tag_ext);
    new_e.rdy2 = prs2_valid_i || (P0_ALWAYS_READY && (prs2_addr_i == '0))
                 || tag_match(prs2_addr_i, cdb_en_ext, cdb_tag_ext);
  end

  // Wakeup, then collapse above the issued slot, then append the new entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i]      = entries_q[i];
      woken[i].rdy1 = entries_q[i].rdy1 || tag_match(entries_q[i].prs1, cdb_en_ext, cdb_tag_ext);
      woken[i].rdy2 = entries_q[i].rdy2 || tag_match(entries_q[i].prs2, cdb_en_ext, cdb_tag_ext);
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      shifted[i] = woken[i+1];
    end
    shifted[DEPTH-1] = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (IDX_W'(i) >= sel_idx)) entries_d[i] = shifted[i];
      else                                      entries_d[i] = woken[i];
      if (alloc_fire && (CW'(i) == wr_slot))    entries_d[i] = new_e;
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({alloc_fire, issue_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_ni) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_rs_queue.sv
module tb_rs_queue;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        flush_i;
  logic        alloc_valid_i;
  logic        alloc_ready_o;
  logic [31:0] pc_i, inst_i;
  logic [5:0]  prs1_addr_i, prs2_addr_i, prd_addr_i;
  logic        prs1_valid_i, prs2_valid_i;
  logic [1:0]  cdb_en_i;
  logic [11:0] cdb_tag_i;
  logic        issue_valid_o;
  logic        fu_ready_i;
  logic [31:0] issue_pc_o, issue_inst_o;
  logic [5:0]  issue_prs1_addr_o, issue_prs2_addr_o, issue_prd_addr_o;
  logic [3:0]  count_o;

  typedef struct {
    logic [31:0] pc;
    logic [5:0]  prd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk_i = ~clk_i;

  rs_queue #(.DEPTH(8), .NUM_CDB(2), .PREG_W(6), .XLEN(32), .P0_ALWAYS_READY(1'b1)) dut (
    .clk_i             (clk_i),
    .reset_ni          (reset_ni),
    .flush_i           (flush_i),
    .alloc_valid_i     (alloc_valid_i),
    .alloc_ready_o     (alloc_ready_o),
    .pc_i              (pc_i),
    .inst_i            (inst_i),
    .prs1_addr_i       (prs1_addr_i),
    .prs2_addr_i       (prs2_addr_i),
    .prd_addr_i        (prd_addr_i),
    .prs1_valid_i      (prs1_valid_i),
    .prs2_valid_i      (prs2_valid_i),
    .cdb_en_i          (cdb_en_i),
    .cdb_tag_i         (cdb_tag_i),
    .issue_valid_o     (issue_valid_o),
    .fu_ready_i        (fu_ready_i),
    .issue_pc_o        (issue_pc_o),
    .issue_inst_o      (issue_inst_o),
    .issue_prs1_addr_o (issue_prs1_addr_o),
    .issue_prs2_addr_o (issue_prs2_addr_o),
    .issue_prd_addr_o  (issue_prd_addr_o),
    .count_o           (count_o)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor: every accepted issue pops the next expected entry.
  always @(negedge clk_i) begin
    if (reset_ni && issue_valid_o && fu_ready_i && !flush_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got pc 0x%0h prd %0d, expected nothing", issue_pc_o, issue_prd_addr_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("issue_pc", issue_pc_o, e.pc);
        chk("issue_prd", {26'd0, issue_prd_addr_o}, {26'd0, e.prd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle;
    alloc_valid_i = 1'b0;
    cdb_en_i      = 2'b00;
    cdb_tag_i     = '0;
    flush_i       = 1'b0;
  endtask

  task automatic expect_issue(input logic [31:0] pc, input logic [5:0] prd);
    exp_t e;
    e.pc  = pc;
    e.prd = prd;
    exp_q.push_back(e);
  endtask

  task automatic alloc_set(input logic [31:0] pc, input logic [5:0] s1, input logic v1,
                           input logic [5:0] s2, input logic v2, input logic [5:0] prd);
    alloc_valid_i = 1'b1;
    pc_i          = pc;
    inst_i        = pc ^ 32'hA5A5_0000;
    prs1_addr_i   = s1;
    prs1_valid_i  = v1;
    prs2_addr_i   = s2;
    prs2_valid_i  = v2;
    prd_addr_i    = prd;
  endtask

  task automatic cdb_set(input logic [1:0] en, input logic [5:0] t0, input logic [5:0] t1);
    cdb_en_i  = en;
    cdb_tag_i = {t1, t0};
  endtask

  initial begin
    reset_ni   = 1'b0;
    fu_ready_i = 1'b0;
    pc_i = '0; inst_i = '0; prs1_addr_i = '0; prs2_addr_i = '0; prd_addr_i = '0;
    prs1_valid_i = 1'b0; prs2_valid_i = 1'b0;
    idle();
    repeat (3) tick();
    chk("rst_alloc_ready", {31'd0, alloc_ready_o}, 32'd1);
    chk("rst_issue_valid", {31'd0, issue_valid_o}, 32'd0);
    chk("rst_count", {28'd0, count_o}, 32'd0);
    chk("rst_issue_pc", issue_pc_o, 32'd0);
    reset_ni = 1'b1;
    tick();

    // 1: basic wakeup and issue
    alloc_set(32'h0, 6'd2, 1'b0, 6'd3, 1'b1, 6'd1);
    tick(); idle();
    chk("t1_count_after_alloc", {28'd0, count_o}, 32'd1);
    chk("t1_not_ready", {31'd0, issue_valid_o}, 32'd0);
    cdb_set(2'b01, 6'd2, 6'd0);
    tick(); idle();
    chk("t1_woken_valid", {31'd0, issue_valid_o}, 32'd1);
    chk("t1_woken_prd", {26'd0, issue_prd_addr_o}, 32'd1);
    expect_issue(32'h0, 6'd1);
    fu_ready_i = 1'b1;
    tick();
    fu_ready_i = 1'b0;
    chk("t1_count_after_issue", {28'd0, count_o}, 32'd0);

    // 2: age ordering among ready entries
    alloc_set(32'h100, 6'd5, 1'b0, 6'd0, 1'b0, 6'd10); tick();
    alloc_set(32'h104, 6'd6, 1'b0, 6'd0, 1'b0, 6'd11); tick(); idle();
    expect_issue(32'h104, 6'd11);
    expect_issue(32'h100, 6'd10);
    fu_ready_i = 1'b1;
    cdb_set(2'b01, 6'd6, 6'd0); tick();
    cdb_set(2'b01, 6'd5, 6'd0); tick(); idle();
    tick();
    fu_ready_i = 1'b0;
    chk("t2a_count", {28'd0, count_o}, 32'd0);
    alloc_set(32'h108, 6'd5, 1'b0, 6'd0, 1'b0, 6'd12); tick();
    alloc_set(32'h10C, 6'd6, 1'b0, 6'd0, 1'b0, 6'd13); tick(); idle();
    expect_issue(32'h108, 6'd12);
    expect_issue(32'h10C, 6'd13);
    cdb_set(2'b11, 6'd5, 6'd6); tick(); idle();
    fu_ready_i = 1'b1;
    tick(); tick();
    fu_ready_i = 1'b0;
    chk("t2b_count", {28'd0, count_o}, 32'd0);

    // 3: same-cycle capture on channel 1 at allocation
    alloc_set(32'h200, 6'd7, 1'b0, 6'd8, 1'b1, 6'd20);
    cdb_set(2'b10, 6'd0, 6'd7);
    tick(); idle();
    chk("t3_capture_valid", {31'd0, issue_valid_o}, 32'd1);
    chk("t3_capture_prd", {26'd0, issue_prd_addr_o}, 32'd20);
    expect_issue(32'h200, 6'd20);
    fu_ready_i = 1'b1;
    tick();
    fu_ready_i = 1'b0;
    chk("t3_count", {28'd0, count_o}, 32'd0);

    // 4: full station, issue from the middle, append behind survivors
    for (int i = 0; i < 8; i++) begin
      alloc_set(32'h300 + 32'(4*i), 6'(30 + i), 1'b0, 6'd0, 1'b0, 6'(40 + i));
      tick();
    end
    idle();
    chk("t4_full_count", {28'd0, count_o}, 32'd8);
    chk("t4_full_not_ready", {31'd0, alloc_ready_o}, 32'd0);
    alloc_set(32'h3F0, 6'd63, 1'b0, 6'd0, 1'b0, 6'd63);
    tick(); idle();
    chk("t4_full_ignore", {28'd0, count_o}, 32'd8);
    cdb_set(2'b01, 6'd33, 6'd0);
    tick(); idle();
    chk("t4_slot3_prd", {26'd0, issue_prd_addr_o}, 32'd43);
    expect_issue(32'h30C, 6'd43);
    fu_ready_i = 1'b1;
    alloc_set(32'h400, 6'd50, 1'b0, 6'd0, 1'b0, 6'd50);
    tick();
    fu_ready_i = 1'b0;
    chk("t4_count_after_issue", {28'd0, count_o}, 32'd7);
    tick(); idle();
    chk("t4_count_refill", {28'd0, count_o}, 32'd8);
    expect_issue(32'h31C, 6'd47);
    expect_issue(32'h400, 6'd50);
    fu_ready_i = 1'b1;
    cdb_set(2'b11, 6'd37, 6'd50);
    tick(); idle();
    tick(); tick();
    chk("t4_count_six", {28'd0, count_o}, 32'd6);
    expect_issue(32'h300, 6'd40);
    expect_issue(32'h304, 6'd41);
    expect_issue(32'h308, 6'd42);
    expect_issue(32'h310, 6'd44);
    expect_issue(32'h314, 6'd45);
    expect_issue(32'h318, 6'd46);
    cdb_set(2'b11, 6'd30, 6'd31); tick();
    cdb_set(2'b11, 6'd32, 6'd34); tick();
    cdb_set(2'b11, 6'd35, 6'd36); tick();
    idle();
    for (int c = 0; c < 20 && count_o != 0; c++) tick();
    fu_ready_i = 1'b0;
    chk("t4_drained", {28'd0, count_o}, 32'd0);

    // 5: hold under backpressure, then issue with simultaneous allocate
    alloc_set(32'h500, 6'd1, 1'b1, 6'd2, 1'b1, 6'd55);
    tick(); idle();
    for (int c = 0; c < 3; c++) begin
      chk("t5_hold_valid", {31'd0, issue_valid_o}, 32'd1);
      chk("t5_hold_pc", issue_pc_o, 32'h500);
      chk("t5_hold_inst", issue_inst_o, 32'h500 ^ 32'hA5A5_0000);
      chk("t5_hold_count", {28'd0, count_o}, 32'd1);
      tick();
    end
    expect_issue(32'h500, 6'd55);
    fu_ready_i = 1'b1;
    alloc_set(32'h504, 6'd60, 1'b0, 6'd0, 1'b0, 6'd56);
    tick(); idle();
    fu_ready_i = 1'b0;
    chk("t5_count_unchanged", {28'd0, count_o}, 32'd1);
    chk("t5_new_waiting", {31'd0, issue_valid_o}, 32'd0);

    // 6: flush overrides allocate and issue; async reset
    alloc_set(32'h600, 6'd9, 1'b0, 6'd0, 1'b0, 6'd57); tick();
    alloc_set(32'h604, 6'd10, 1'b0, 6'd0, 1'b0, 6'd58); tick();
    alloc_set(32'h608, 6'd11, 1'b1, 6'd12, 1'b1, 6'd59); tick(); idle();
    chk("t6_count4", {28'd0, count_o}, 32'd4);
    chk("t6_ready_prd", {26'd0, issue_prd_addr_o}, 32'd59);
    alloc_set(32'h60C, 6'd13, 1'b1, 6'd14, 1'b1, 6'd60);
    flush_i    = 1'b1;
    fu_ready_i = 1'b1;
    tick(); idle();
    fu_ready_i = 1'b0;
    chk("t6_flush_count", {28'd0, count_o}, 32'd0);
    chk("t6_flush_valid", {31'd0, issue_valid_o}, 32'd0);
    chk("t6_flush_alloc_ready", {31'd0, alloc_ready_o}, 32'd1);
    alloc_set(32'h700, 6'd15, 1'b1, 6'd16, 1'b1, 6'd62); tick();
    alloc_set(32'h704, 6'd17, 1'b1, 6'd18, 1'b1, 6'd63); tick(); idle();
    chk("t6_pre_reset_count", {28'd0, count_o}, 32'd2);
    chk("t6_pre_reset_valid", {31'd0, issue_valid_o}, 32'd1);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("t6_areset_count", {28'd0, count_o}, 32'd0);
    chk("t6_areset_valid", {31'd0, issue_valid_o}, 32'd0);
    chk("t6_areset_alloc_ready", {31'd0, alloc_ready_o}, 32'd1);
    chk("t6_areset_prd", {26'd0, issue_prd_addr_o}, 32'd0);
    chk("t6_areset_pc", issue_pc_o, 32'd0);
    tick();
    reset_ni = 1'b1;
    tick();
    alloc_set(32'h800, 6'd0, 1'b0, 6'd0, 1'b0, 6'd21);
    tick(); idle();
    expect_issue(32'h800, 6'd21);
    fu_ready_i = 1'b1;
    tick();
    fu_ready_i = 1'b0;
    chk("t6_post_reset_count", {28'd0, count_o}, 32'd0);

    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rs_queue.md
Name: rs_queue

Overview:
- Parametrised, age-ordered reservation station for one functional-unit class (ALU, MUL or LSU). It is the next-generation replacement for the fixed three-slot rs.
- Rename/dispatch allocates one instruction per cycle. Up to NUM_CDB broadcast tags per cycle wake up waiting operands.
- Each cycle, the oldest entry with both operands ready is offered to the FU through a valid/ready handshake.
- A flush input empties the station on branch mispredict.

Parameters:
DEPTH, 8, number of entries (2..32)
NUM_CDB, 2, number of CDB wakeup channels (1..4)
PREG_W, 6, physical register address width
XLEN, 32, pc/inst width
P0_ALWAYS_READY, 1, when 1 a source tag of 0 is ready at allocation

Ports:
clk_i  in  1  clock, rising edge
reset_ni  in  1  asynchronous active-low reset
flush_i  in  1  drop all entries
alloc_valid_i  in  1  allocate request
alloc_ready_o  out  1  space available (entry count < DEPTH)
pc_i  in  XLEN  instruction pc
inst_i  in  XLEN  instruction word
prs1_addr_i  in  PREG_W  source 1 tag
prs2_addr_i  in  PREG_W  source 2 tag
prd_addr_i  in  PREG_W  destination tag
prs1_valid_i  in  1  source 1 already available
prs2_valid_i  in  1  source 2 already available
cdb_en_i  in  NUM_CDB  per-channel broadcast valid
cdb_tag_i  in  NUM_CDB*PREG_W  per-channel tag, channel k at [k*PREG_W +: PREG_W]
issue_valid_o  out  1  a ready entry is offered
fu_ready_i  in  1  FU accepts the offered entry
issue_pc_o  out  XLEN  selected entry pc
issue_inst_o  out  XLEN  selected entry inst
issue_prs1_addr_o  out  PREG_W  selected entry source 1 tag
issue_prs2_addr_o  out  PREG_W  selected entry source 2 tag
issue_prd_addr_o  out  PREG_W  selected entry destination tag
count_o  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Storage is a collapsing queue. Slots 0..count-1 are valid, and slot 0 is the oldest.
- Each entry holds {pc, inst, prs1, rdy1, prs2, rdy2, prd}.
- Reset (reset_ni low, async):
  - count = 0 and all valid bits are 0.
  - alloc_ready_o = 1, issue_valid_o = 0, count_o = 0.
  - issue_* data outputs are 0.
- Allocation fires when alloc_valid_i && alloc_ready_o && !flush_i.
- alloc_ready_o = (count < DEPTH), registered-state only. It never depends on same-cycle issue, so a full station does not accept even when an issue occurs.
- The new entry is written at slot count, or count-1 if an issue also fires this cycle.
- Ready bits at allocation: rdyN = prsN_valid_i OR (P0_ALWAYS_READY && prsN == 0) OR (any k: cdb_en_i[k] && cdb_tag_i[k] == prsN). This same-cycle CDB capture is mandatory.
- Wakeup: for each valid entry and each channel k, if cdb_en_i[k] and the tag matches prs1 (or prs2), set rdy1 (or rdy2) at the clock edge.
- A woken entry becomes issue-eligible in the next cycle, giving wakeup-to-issue latency 1. There is no combinational CDB-to-issue path.
- Select: issue_valid_o = OR over valid slots of (rdy1 && rdy2). The issue_* outputs show the lowest-index ready slot. issue_* outputs are combinational from registered state only.
- When issue_valid_o is 0, issue_* outputs are 0.
- Issue fires when issue_valid_o && fu_ready_i && !flush_i.
  - At the clock edge the selected slot is removed. Slots above it shift down by one, keeping their ready bits and that cycle's wakeups.
  - While fu_ready_i is 0, the offered entry and its outputs hold stable. An older entry becoming ready may change the selection; this is permitted.
- Simultaneous allocate + issue: count is unchanged. The compaction and the write are both correct; the new entry lands behind all survivors.
- Flush: at the next edge count = 0, overriding allocate and issue in the same cycle. Reset mid-operation discards everything asynchronously.
- Duplicate tags (prs1 == prs2) are legal; both ready bits are set by one broadcast.
- Multiple channels matching the same entry in one cycle are harmless (the set is idempotent).
- count never exceeds DEPTH and never underflows. An assertion checks count <= DEPTH.

Decomposition:
- rs_pkg holds:
  - a typedef for rs_entry_t (pc, inst, prs1, rdy1, prs2, rdy2, prd);
  - localparam CNT_W;
  - a function tag_match(tag, cdb_en, cdb_tag) returning 1 if any enabled channel matches.
- Sub-module rs_select: a parametrised priority encoder over DEPTH ready bits returning {found, index}. It is reused by the LSU queue.

Test Plan:
1. Reset, then allocate pc=0 prs1=2 (not valid), prs2=3 (valid), prd=1 -> count_o=1, issue_valid_o=0. Then cdb_en=01, tag0=2 -> issue_valid_o=1 next cycle with issue_prd_addr_o=1. With fu_ready_i=1 -> count_o=0 after the edge.
2. Allocate A(prs1=5, wait) then B(prs1=6, wait); broadcast 6 then 5 -> B issues first. Broadcast both on channels 0 and 1 in the same cycle -> A (slot 0) issues before B.
3. Allocate prs1=7 (not valid) while cdb_en=10, tag1=7 in the same cycle -> the entry is ready and issue_valid_o=1 in the following cycle.
4. Fill DEPTH=8 entries, all waiting -> alloc_ready_o=0 and a further alloc_valid_i is ignored (count_o stays 8). Wake slot 3, fu_ready_i=1, allocate same cycle -> count_o stays 7 then 8, and the new entry lands at slot 7.
5. Ready entry with fu_ready_i=0 for 3 cycles -> issue_* outputs stable and count unchanged; fu_ready_i=1 -> removed.
6. Hold 4 entries, assert flush_i together with alloc_valid_i and fu_ready_i -> count_o=0 and issue_valid_o=0 next cycle. Drop reset_ni mid-stream -> outputs at reset values immediately, without waiting for a clock edge.
